// File: rtl/bc_display_fsm.sv
// Bulls & Cows game controller.
// Handles secret entry for both players, alternating guesses, validation,
// scoring, and the error/result/win screens. The display slots carry codes
// in the form {symbol[4:0], enable} for a downstream segment decoder.
module bc_display_fsm #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_DISPLAYS = 8,
  parameter int CODE_W       = 6,
  parameter int ERR_CYCLES   = 50_000_000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             confirm,
  input  logic [4*NUM_DIGITS-1:0]          digits_in,
  output logic [NUM_DISPLAYS*CODE_W-1:0]   disp,
  output logic [2:0]                       state_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  bulls,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  cows,
  output logic [1:0]                       winner
);

  localparam int BW    = $clog2(NUM_DIGITS + 1);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  localparam logic [4:0] SYM_DASH = 5'd16;
  localparam logic [4:0] SYM_J    = 5'd17;
  localparam logic [4:0] SYM_B    = 5'd18;
  localparam logic [4:0] SYM_C    = 5'd19;
  localparam logic [4:0] SYM_E    = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SECRET_J1 = 3'd1,
    S_SECRET_J2 = 3'd2,
    S_GUESS_J1  = 3'd3,
    S_GUESS_J2  = 3'd4,
    S_RESULT    = 3'd5,
    S_ERROR     = 3'd6,
    S_WIN       = 3'd7
  } state_t;

  function automatic logic [CODE_W-1:0] sym(input logic [4:0] s);
    return {s, 1'b1};
  endfunction

  state_t            state_q, state_d, ret_state_q, ret_state_d;
  logic [DW-1:0]     secret_j1_q, secret_j1_d, secret_j2_q, secret_j2_d;
  logic [BW-1:0]     bulls_q, bulls_d, cows_q, cows_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              p2_q, p2_d;     // player of the last scored guess (1 = J2)
  logic              conf_q;
  logic              conf_ev;

  logic              entry_ok;
  logic [DW-1:0]     opp_secret;
  logic [BW-1:0]     bulls_n, cows_n;
  logic              hit;

  logic [NUM_DISPLAYS-1:0][CODE_W-1:0] disp_a;

  assign conf_ev = confirm & ~conf_q;

  // Entry validation and scoring of the live digits against the opponent's secret
  always_comb begin
    entry_ok   = 1'b1;
    bulls_n    = '0;
    cows_n     = '0;
    hit        = 1'b0;
    opp_secret = (state_q == S_GUESS_J1) ? secret_j2_q : secret_j1_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) entry_ok = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++)
        if (digits_in[4*i +: 4] == digits_in[4*j +: 4]) entry_ok = 1'b0;
      hit = 1'b0;
      if (digits_in[4*i +: 4] == opp_secret[4*i +: 4]) begin
        bulls_n = bulls_n + BW'(1);
      end else begin
        for (int j = 0; j < NUM_DIGITS; j++)
          if (j != i && digits_in[4*i +: 4] == opp_secret[4*j +: 4]) hit = 1'b1;
        if (hit) cows_n = cows_n + BW'(1);
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    secret_j1_d = secret_j1_q;
    secret_j2_d = secret_j2_q;
    bulls_d     = bulls_q;
    cows_d      = cows_q;
    err_cnt_d   = err_cnt_q;
    p2_d        = p2_q;
    case (state_q)
      S_IDLE: state_d = S_SECRET_J1;
      S_SECRET_J1, S_SECRET_J2, S_GUESS_J1, S_GUESS_J2: begin
        if (conf_ev) begin
          if (!entry_ok) begin
            ret_state_d = state_q;
            err_cnt_d   = ERR_W'(ERR_CYCLES - 1);
            state_d     = S_ERROR;
          end else begin
            case (state_q)
              S_SECRET_J1: begin secret_j1_d = digits_in; state_d = S_SECRET_J2; end
              S_SECRET_J2: begin secret_j2_d = digits_in; state_d = S_GUESS_J1;  end
              default: begin
                bulls_d = bulls_n;
                cows_d  = cows_n;
                p2_d    = (state_q == S_GUESS_J2);
                state_d = S_RESULT;
              end
            endcase
          end
        end
      end
      S_RESULT: begin
        if (conf_ev) begin
          if (bulls_q == BW'(NUM_DIGITS)) state_d = S_WIN;
          else                            state_d = p2_q ? S_GUESS_J1 : S_GUESS_J2;
        end
      end
      S_ERROR: begin
        // confirm presses are dropped here; the counter alone sets the duration
        if (err_cnt_q == '0) state_d = ret_state_q;
        else                 err_cnt_d = err_cnt_q - ERR_W'(1);
      end
      S_WIN: begin
        if (conf_ev) begin
          secret_j1_d = '0;
          secret_j2_d = '0;
          bulls_d     = '0;
          cows_d      = '0;
          p2_d        = 1'b0;
          state_d     = S_SECRET_J1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_state_q <= S_IDLE;
      secret_j1_q <= '0;
      secret_j2_q <= '0;
      bulls_q     <= '0;
      cows_q      <= '0;
      err_cnt_q   <= '0;
      p2_q        <= 1'b0;
      conf_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      secret_j1_q <= secret_j1_d;
      secret_j2_q <= secret_j2_d;
      bulls_q     <= bulls_d;
      cows_q      <= cows_d;
      err_cnt_q   <= err_cnt_d;
      p2_q        <= p2_d;
      conf_q      <= confirm;
    end
  end

  // Screen composition from registered state (plus live digit echo)
  always_comb begin
    disp_a = '0;
    case (state_q)
      S_IDLE: for (int k = 0; k < NUM_DISPLAYS; k++) disp_a[k] = sym(SYM_DASH);
      S_SECRET_J1, S_SECRET_J2, S_GUESS_J1, S_GUESS_J2: begin
        disp_a[NUM_DISPLAYS-1] = sym(SYM_J);
        disp_a[NUM_DISPLAYS-2] = (state_q == S_SECRET_J1 || state_q == S_GUESS_J1)
                                 ? sym(5'd1) : sym(5'd2);
        for (int k = 0; k < NUM_DIGITS; k++)
          if (digits_in[4*k +: 4] <= 4'd9) disp_a[k] = sym({1'b0, digits_in[4*k +: 4]});
      end
      S_RESULT: begin
        disp_a[5] = sym(SYM_J);
        disp_a[4] = p2_q ? sym(5'd2) : sym(5'd1);
        disp_a[3] = sym(5'(bulls_q));
        disp_a[2] = sym(SYM_B);
        disp_a[1] = sym(5'(cows_q));
        disp_a[0] = sym(SYM_C);
      end
      S_ERROR: for (int k = 0; k < NUM_DISPLAYS; k++) disp_a[k] = sym(SYM_E);
      default: begin
        for (int k = 0; k < NUM_DISPLAYS; k++) disp_a[k] = sym(SYM_DASH);
        disp_a[NUM_DISPLAYS-1] = sym(SYM_J);
        disp_a[NUM_DISPLAYS-2] = p2_q ? sym(5'd2) : sym(5'd1);
      end
    endcase
  end

  assign disp    = disp_a;
  assign state_o = state_q;
  assign bulls   = bulls_q;
  assign cows    = cows_q;
  assign winner  = (state_q == S_WIN) ? (p2_q ? 2'd2 : 2'd1) : 2'd0;

endmodule

// File: tb/tb_bc_display_fsm.sv
// Testbench for bc_display_fsm: directed game flow followed by random play,
// every cycle compared against a game-level model of the rules.
module tb_bc_display_fsm;
  localparam int ND = 4, NDISP = 8, CW = 6, ERRC = 5, BW = 3;

  logic                  clock = 1'b0;
  logic                  reset, confirm;
  logic [4*ND-1:0]       digits_in;
  logic [NDISP*CW-1:0]   disp;
  logic [2:0]            state_o;
  logic [BW-1:0]         bulls, cows;
  logic [1:0]            winner;

  bc_display_fsm #(.NUM_DIGITS(ND), .NUM_DISPLAYS(NDISP), .CODE_W(CW), .ERR_CYCLES(ERRC)) dut (
    .clock(clock), .reset(reset), .confirm(confirm), .digits_in(digits_in),
    .disp(disp), .state_o(state_o), .bulls(bulls), .cows(cows), .winner(winner)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- game model ----------------
  int mst, mret, merr, mb, mc, mp;
  int s1[ND], s2[ND];
  bit mprev;

  function automatic int nib(input logic [4*ND-1:0] d, input int k);
    logic [3:0] n;
    n = d[4*k +: 4];
    return int'(n);
  endfunction

  // legal entry: decimal digits, each used at most once
  function automatic bit legal(input logic [4*ND-1:0] d);
    bit seen[16];
    for (int k = 0; k < 16; k++) seen[k] = 0;
    for (int k = 0; k < ND; k++) begin
      if (nib(d, k) > 9 || seen[nib(d, k)]) return 0;
      seen[nib(d, k)] = 1;
    end
    return 1;
  endfunction

  // cows = shared digits minus exact matches (both sides have distinct digits)
  task automatic score(input logic [4*ND-1:0] g, input int s[ND], output int b, output int c);
    int common;
    b = 0; common = 0;
    for (int k = 0; k < ND; k++) begin
      if (nib(g, k) == s[k]) b++;
      for (int j = 0; j < ND; j++) if (nib(g, k) == s[j]) common++;
    end
    c = common - b;
  endtask

  task automatic m_reset();
    mst = 0; mret = 0; merr = 0; mb = 0; mc = 0; mp = 0; mprev = 0;
    for (int k = 0; k < ND; k++) begin s1[k] = 0; s2[k] = 0; end
  endtask

  task automatic m_step();
    bit ev;
    ev = confirm && !mprev;
    mprev = confirm;
    case (mst)
      0: mst = 1;
      1, 2, 3, 4: if (ev) begin
        if (!legal(digits_in)) begin
          mret = mst; merr = ERRC; mst = 6;
        end else if (mst == 1) begin
          for (int k = 0; k < ND; k++) s1[k] = nib(digits_in, k);
          mst = 2;
        end else if (mst == 2) begin
          for (int k = 0; k < ND; k++) s2[k] = nib(digits_in, k);
          mst = 3;
        end else if (mst == 3) begin
          score(digits_in, s2, mb, mc); mp = 1; mst = 5;
        end else begin
          score(digits_in, s1, mb, mc); mp = 2; mst = 5;
        end
      end
      5: if (ev) mst = (mb == ND) ? 7 : ((mp == 1) ? 4 : 3);
      6: begin
        merr--;
        if (merr == 0) mst = mret;
      end
      default: if (ev) begin
        for (int k = 0; k < ND; k++) begin s1[k] = 0; s2[k] = 0; end
        mb = 0; mc = 0; mst = 1;
      end
    endcase
  endtask

  function automatic logic [5:0] sy(input int s);
    logic [4:0] t;
    t = s[4:0];
    return {t, 1'b1};
  endfunction

  function automatic logic [NDISP*CW-1:0] exp_disp();
    logic [5:0] e[NDISP];
    logic [NDISP*CW-1:0] r;
    for (int k = 0; k < NDISP; k++) e[k] = 6'd0;
    case (mst)
      0: for (int k = 0; k < NDISP; k++) e[k] = sy(16);
      1, 2, 3, 4: begin
        e[NDISP-1] = sy(17);
        e[NDISP-2] = sy((mst == 1 || mst == 3) ? 1 : 2);
        for (int k = 0; k < ND; k++) if (nib(digits_in, k) <= 9) e[k] = sy(nib(digits_in, k));
      end
      5: begin
        e[5] = sy(17); e[4] = sy(mp); e[3] = sy(mb);
        e[2] = sy(18); e[1] = sy(mc); e[0] = sy(19);
      end
      6: for (int k = 0; k < NDISP; k++) e[k] = sy(20);
      default: begin
        for (int k = 0; k < NDISP; k++) e[k] = sy(16);
        e[NDISP-1] = sy(17); e[NDISP-2] = sy(mp);
      end
    endcase
    for (int k = 0; k < NDISP; k++) r[k*CW +: CW] = e[k];
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_state"},  64'(state_o), 64'(mst));
    chk({tag, "_bulls"},  64'(bulls),   64'(mb));
    chk({tag, "_cows"},   64'(cows),    64'(mc));
    chk({tag, "_winner"}, 64'(winner),  64'((mst == 7) ? mp : 0));
    chk({tag, "_disp"},   64'(disp),    64'(exp_disp()));
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic pulse(input logic [4*ND-1:0] d, input string tag);
    digits_in = d; confirm = 1'b1;
    tick(tag);
    confirm = 1'b0;
    tick(tag);
  endtask

  function automatic logic [4*ND-1:0] rnd_valid();
    int d[10];
    int j, t;
    logic [4*ND-1:0] r;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 0; i < ND; i++) begin
      j = $urandom_range(9, i);
      t = d[i]; d[i] = d[j]; d[j] = t;
      r[4*i +: 4] = 4'(d[i]);
    end
    return r;
  endfunction

  function automatic logic [4*ND-1:0] opp_code();
    logic [4*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((mst == 3) ? s2[k] : s1[k]);
    return r;
  endfunction

  initial begin
    logic [31:0] rv;
    reset = 1'b1; confirm = 1'b0; digits_in = '0;
    m_reset();
    @(posedge clock); #1;
    check_all("rst");
    @(negedge clock); reset = 1'b0;
    #1 check_all("idle");
    tick("to_s1");
    chk("plan_s1", 64'(state_o), 64'd1);

    // duplicate digit secret -> error screen for ERRC cycles, press ignored
    digits_in = 16'h1123; confirm = 1'b1;
    tick("err_in");
    chk("plan_err", 64'(state_o), 64'd6);
    confirm = 1'b0; tick("err");
    confirm = 1'b1; tick("err_press");
    confirm = 1'b0; tick("err");
    tick("err");
    chk("plan_err_last", 64'(state_o), 64'd6);
    tick("err_out");
    chk("plan_err_back", 64'(state_o), 64'd1);

    // held confirm gives a single transition
    digits_in = 16'h1234; confirm = 1'b1;
    repeat (20) tick("hold");
    confirm = 1'b0; tick("hold_rel");
    chk("plan_hold", 64'(state_o), 64'd2);
    pulse(16'h5678, "sec2");
    chk("plan_g1", 64'(state_o), 64'd3);
    pulse(16'h5687, "guess1");
    chk("plan_b22", 64'({bulls, cows}), 64'({3'd2, 3'd2}));
    chk("plan_res_disp", 64'(disp[35:0]), 64'({6'h23, 6'h03, 6'h05, 6'h25, 6'h05, 6'h27}));
    pulse(16'h5687, "res1");
    chk("plan_g2", 64'(state_o), 64'd4);
    pulse(16'h1234, "guess2");
    chk("plan_b4", 64'(bulls), 64'd4);
    pulse(16'h1234, "to_win");
    chk("plan_win", 64'(winner), 64'd2);
    pulse(16'h1234, "new_game");
    chk("plan_new", 64'({state_o, bulls, winner}), 64'({3'd1, 3'd0, 2'd0}));

    // reach GUESS_J2 then reset asynchronously mid-cycle
    pulse(16'h1234, "a_s1");
    pulse(16'h5678, "a_s2");
    pulse(16'h9012, "a_g1");
    pulse(16'h9012, "a_res");
    chk("plan_pre_rst", 64'(state_o), 64'd4);
    #2 reset = 1'b1;
    #1 m_reset();
    check_all("async_rst");
    @(negedge clock); reset = 1'b0;

    // random play
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        rv = $urandom();
        case ($urandom_range(9))
          0, 1:    digits_in = rv[4*ND-1:0];
          2, 3, 4: digits_in = ((mst == 3 || mst == 4) && rv[31]) ? opp_code() : rnd_valid();
          default: digits_in = rnd_valid();
        endcase
      end
      confirm = ($urandom_range(2) == 0);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
